// File: rtl/dll_pkg.sv
// Shared types and constants for the DLL delay-code manager.
package dll_pkg;

    typedef enum logic [2:0] {
        OFF,
        PWRUP,
        LOCK_WAIT,
        UPDATE,
        SAMPLE,
        DISTRIBUTE,
        TRACK
    } dll_state_t;

    // Cycles SAMPLE waits after the update pulse before latching the DLL code.
    localparam int SAMPLE_DLY = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dll_lock_filt.sv
// Consecutive-cycle qualifier for raw DLL lock: reports gain after LOCK_FILT
// high cycles and loss after LOCK_FILT low cycles, each only while enabled.
module dll_lock_filt #(
    parameter int LOCK_FILT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_in,
    input  logic gain_en,
    input  logic loss_en,
    output logic gain,
    output logic loss
);

    localparam int CNT_W = $clog2(LOCK_FILT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILT - 1);

    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            hi_cnt <= (gain_en && lock_in)  ? sat_inc(hi_cnt) : '0;
            lo_cnt <= (loss_en && !lock_in) ? sat_inc(lo_cnt) : '0;
        end
    end

    // The current cycle completes the run, so the decision is taken without an extra cycle.
    assign gain = gain_en && lock_in  && (hi_cnt >= CNT_LAST);
    assign loss = loss_en && !lock_in && (lo_cnt >= CNT_LAST);

endmodule

// File: rtl/dll_code_mgr.sv
// DLL power/lock sequencing with periodic code refresh and per-lane
// valid/ack distribution of the captured delay code.
module dll_code_mgr
    import dll_pkg::*;
#(
    parameter int CODE_W        = 8,
    parameter int NUM_LANES     = 2,
    parameter int PWRUP_WAIT    = 64,
    parameter int LOCK_FILT     = 16,
    parameter int UPDATE_PERIOD = 1024
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic                          DLL_LOCK,
    input  logic                          DLL_DELAY_DIFF,
    input  logic [CODE_W-1:0]             DLL_CODE,
    output logic                          DLL_POWERDOWN_N,
    output logic                          DLL_CODE_UPDATE,
    output logic [NUM_LANES*CODE_W-1:0]   LANE_CODE,
    output logic [NUM_LANES-1:0]          LANE_VALID,
    input  logic [NUM_LANES-1:0]          LANE_ACK,
    output logic                          LOCKED,
    output logic                          LOCK_LOST
);

    localparam int CNT_TOP = max_int(max_int(PWRUP_WAIT, UPDATE_PERIOD), SAMPLE_DLY);
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST  = CNT_W'(PWRUP_WAIT - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(UPDATE_PERIOD - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CAP  = CNT_W'(SAMPLE_DLY - 1);
    localparam logic [CNT_W-1:0] SAMPLE_END  = CNT_W'(SAMPLE_DLY);

    dll_state_t state;
    dll_state_t next_state;

    logic [CNT_W-1:0]            cnt;
    logic [CODE_W-1:0]           cap_code;
    logic [NUM_LANES*CODE_W-1:0] lane_code;
    logic [NUM_LANES-1:0]        lane_valid;
    logic [NUM_LANES-1:0]        lane_valid_nxt;
    logic                        distributed;
    logic                        enable_q;
    logic                        lock_lost_q;
    logic                        gain;
    logic                        loss;
    logic                        loss_en;
    logic                        lock_lost_evt;
    logic                        load;
    logic                        drop_valid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign loss_en = (state inside {UPDATE, SAMPLE, DISTRIBUTE, TRACK});

    dll_lock_filt #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_filt (
        .clk     (CLK),
        .rst     (RESET),
        .lock_in (DLL_LOCK),
        .gain_en (state == LOCK_WAIT),
        .loss_en (loss_en),
        .gain    (gain),
        .loss    (loss)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= OFF;
        end else begin
            state <= next_state;
        end
    end

    // Disable beats lock loss, which beats every forward transition.
    always_comb begin
        next_state = state;
        if (!ENABLE) begin
            next_state = OFF;
        end else if (loss) begin
            next_state = LOCK_WAIT;
        end else begin
            case (state)
                OFF:        next_state = PWRUP;
                PWRUP:      if (cnt == PWRUP_LAST) next_state = LOCK_WAIT;
                LOCK_WAIT:  if (gain) next_state = UPDATE;
                UPDATE:     next_state = SAMPLE;
                SAMPLE: begin
                    if (cnt == SAMPLE_END) begin
                        if (distributed && (cap_code == lane_code[CODE_W-1:0])) begin
                            next_state = TRACK;
                        end else begin
                            next_state = DISTRIBUTE;
                        end
                    end
                end
                DISTRIBUTE: if (lane_valid == '0) next_state = TRACK;
                TRACK:      if (DLL_DELAY_DIFF || (cnt == PERIOD_LAST)) next_state = UPDATE;
                default:    next_state = OFF;
            endcase
        end
    end

    always_comb begin
        DLL_POWERDOWN_N = (state != OFF);
        DLL_CODE_UPDATE = (state == UPDATE);
        LOCKED          = (state == TRACK);
        LOCK_LOST       = lock_lost_q && (state != OFF);
    end

    assign lock_lost_evt = ENABLE && loss;
    assign load          = (state == SAMPLE) && (next_state == DISTRIBUTE);
    assign drop_valid    = (next_state == OFF) || lock_lost_evt;

    // One shared state-time counter, restarted on every state change.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else begin
            cnt <= sat_inc(cnt);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cap_code <= '0;
        end else if ((state == SAMPLE) && (cnt == SAMPLE_CAP)) begin
            cap_code <= DLL_CODE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || (next_state == OFF)) begin
            lane_code <= '0;
        end else if (load) begin
            lane_code <= {NUM_LANES{cap_code}};
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_valid_nxt[i] = load ? 1'b1 : (lane_valid[i] && !LANE_ACK[i]);
    end

    always_ff @(posedge CLK) begin
        if (RESET || drop_valid) begin
            lane_valid <= '0;
        end else begin
            lane_valid <= lane_valid_nxt;
        end
    end

    // A first distribution after (re)lock is forced even if the code is unchanged.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            distributed <= 1'b0;
        end else if (load) begin
            distributed <= 1'b1;
        end else if ((next_state == LOCK_WAIT) || (next_state == OFF)) begin
            distributed <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            enable_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            enable_q <= ENABLE;
            if (ENABLE && !enable_q) begin
                lock_lost_q <= 1'b0;
            end else if (lock_lost_evt) begin
                lock_lost_q <= 1'b1;
            end
        end
    end

    assign LANE_CODE  = lane_code;
    assign LANE_VALID = lane_valid;

endmodule

// File: tb/tb_dll_code_mgr.sv
// Scoreboard bench for dll_code_mgr: predicted update pulses and code
// distributions are queued by the stimulus and matched by a monitor.
module tb_dll_code_mgr;

    localparam int CODE_W        = 8;
    localparam int NUM_LANES     = 2;
    localparam int PWRUP_WAIT    = 64;
    localparam int LOCK_FILT     = 16;
    localparam int UPDATE_PERIOD = 1024;

    logic                        CLK = 1'b0;
    logic                        RESET;
    logic                        ENABLE;
    logic                        DLL_LOCK;
    logic                        DLL_DELAY_DIFF;
    logic [CODE_W-1:0]           DLL_CODE;
    logic                        DLL_POWERDOWN_N;
    logic                        DLL_CODE_UPDATE;
    logic [NUM_LANES*CODE_W-1:0] LANE_CODE;
    logic [NUM_LANES-1:0]        LANE_VALID;
    logic [NUM_LANES-1:0]        LANE_ACK;
    logic                        LOCKED;
    logic                        LOCK_LOST;

    dll_code_mgr #(
        .CODE_W        (CODE_W),
        .NUM_LANES     (NUM_LANES),
        .PWRUP_WAIT    (PWRUP_WAIT),
        .LOCK_FILT     (LOCK_FILT),
        .UPDATE_PERIOD (UPDATE_PERIOD)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .ENABLE          (ENABLE),
        .DLL_LOCK        (DLL_LOCK),
        .DLL_DELAY_DIFF  (DLL_DELAY_DIFF),
        .DLL_CODE        (DLL_CODE),
        .DLL_POWERDOWN_N (DLL_POWERDOWN_N),
        .DLL_CODE_UPDATE (DLL_CODE_UPDATE),
        .LANE_CODE       (LANE_CODE),
        .LANE_VALID      (LANE_VALID),
        .LANE_ACK        (LANE_ACK),
        .LOCKED          (LOCKED),
        .LOCK_LOST       (LOCK_LOST)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  code;
    } dist_t;

    int         nchecks = 0;
    int         nerrors = 0;
    int         exp_pulse_q[$];
    dist_t      exp_dist_q[$];
    dist_t      mon_e;
    logic [1:0] prev_valid = '0;
    logic [7:0] last_dist;
    int         t_track;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Monitor: every pulse / rising LANE_VALID must match the head of its queue.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (DLL_CODE_UPDATE) begin
                if (exp_pulse_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL pulse_unexpected: got pulse at cycle %0d expected none", cyc);
                end else begin
                    check("pulse_cycle", cyc, exp_pulse_q.pop_front());
                end
            end
            if ((LANE_VALID != '0) && (prev_valid == '0)) begin
                if (exp_dist_q.size() == 0) begin
                    nchecks++;
                    nerrors++;
                    $display("FAIL dist_unexpected: got LANE_VALID=%b at cycle %0d expected none", LANE_VALID, cyc);
                end else begin
                    mon_e = exp_dist_q.pop_front();
                    check("dist_cycle", cyc, mon_e.cyc);
                    check("dist_valid", LANE_VALID, 2'b11);
                    check("dist_code", LANE_CODE, {mon_e.code, mon_e.code});
                end
            end
        end
        prev_valid = LANE_VALID;
    end

    // mode 0: period expiry, 1: DELAY_DIFF k cycles into TRACK, 2: DELAY_DIFF on the expiry cycle
    task automatic do_refresh(input int mode, input logic [7:0] nc, input int k);
        int p, d, a0, a1, amax;
        wait_until(t_track);
        DLL_CODE = nc;
        p = (mode == 1) ? t_track + 1 + k : t_track + UPDATE_PERIOD;
        exp_pulse_q.push_back(p);
        if (mode != 0) begin
            wait_until(p - 1);
            DLL_DELAY_DIFF = 1'b1;
            wait_until(p);
            DLL_DELAY_DIFF = 1'b0;
        end
        if (nc != last_dist) begin
            d = p + 4;
            exp_dist_q.push_back('{cyc: d, code: nc});
            a0 = d + int'($urandom_range(0, 5));
            a1 = d + int'($urandom_range(0, 5));
            amax = (a0 > a1) ? a0 : a1;
            for (int c = d; c <= amax; c++) begin
                wait_until(c);
                LANE_ACK = {c == a1, c == a0};
            end
            wait_until(amax + 1);
            LANE_ACK = '0;
            last_dist = nc;
            t_track = amax + 2;
        end else begin
            t_track = p + 4;
        end
        wait_until(t_track - 1);
        check("locked_before_track", LOCKED, 0);
        wait_until(t_track);
        check("locked_in_track", LOCKED, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0, d, L, L2, p, e;
        logic [7:0] nc;

        RESET = 1'b1; ENABLE = 1'b0; DLL_LOCK = 1'b0; DLL_DELAY_DIFF = 1'b0;
        DLL_CODE = '0; LANE_ACK = '0;
        repeat (3) @(negedge CLK);
        // Reset must win over active inputs.
        ENABLE = 1'b1; DLL_LOCK = 1'b1; DLL_CODE = 8'hA5; LANE_ACK = 2'b11; DLL_DELAY_DIFF = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset_pwrdn", DLL_POWERDOWN_N, 0);
        check("reset_update", DLL_CODE_UPDATE, 0);
        check("reset_valid", LANE_VALID, 0);
        check("reset_locked", LOCKED, 0);
        check("reset_lost", LOCK_LOST, 0);
        check("reset_code", LANE_CODE, 0);

        // Bring-up with staggered acks.
        c0 = cyc;
        RESET = 1'b0; ENABLE = 1'b1; DLL_LOCK = 1'b0; DLL_CODE = 8'h5A;
        LANE_ACK = '0; DLL_DELAY_DIFF = 1'b0;
        exp_pulse_q.push_back(c0 + 1 + PWRUP_WAIT + LOCK_FILT);
        d = c0 + 1 + PWRUP_WAIT + LOCK_FILT + 4;
        exp_dist_q.push_back('{cyc: d, code: 8'h5A});
        check("off_pwrdn", DLL_POWERDOWN_N, 0);
        wait_until(c0 + 1);
        check("pwrup_pwrdn", DLL_POWERDOWN_N, 1);
        wait_until(c0 + 10);
        DLL_LOCK = 1'b1;
        for (int c = d; c <= d + 9; c++) begin
            wait_until(c);
            LANE_ACK = {c == d + 7, c == d + 1};
            if (c == d)     check("stagger_valid_11", LANE_VALID, 2'b11);
            if (c == d + 2) check("stagger_valid_10", LANE_VALID, 2'b10);
            if (c == d + 5) check("stagger_code_stable", LANE_CODE, 16'h5A5A);
            if (c == d + 8) begin
                check("stagger_valid_00", LANE_VALID, 2'b00);
                check("stagger_not_locked", LOCKED, 0);
            end
            if (c == d + 9) check("stagger_locked", LOCKED, 1);
        end
        LANE_ACK = '0;
        last_dist = 8'h5A;
        t_track = d + 9;

        // Unchanged-code refresh, changed-code refresh, coincident expiry+drift.
        do_refresh(0, 8'h5A, 0);
        do_refresh(0, 8'h5B, 0);
        do_refresh(2, 8'h5B, 0);

        for (int i = 0; i < 6; i++) begin
            nc = ($urandom_range(0, 2) == 0) ? last_dist : 8'($urandom);
            do_refresh(int'($urandom_range(0, 2)), nc, int'($urandom_range(0, 300)));
        end

        // Lock loss: 15 low cycles tolerated, 16 trip.
        L = t_track + 2;
        wait_until(L);
        DLL_LOCK = 1'b0;
        wait_until(L + LOCK_FILT - 1);
        DLL_LOCK = 1'b1;
        wait_until(L + LOCK_FILT);
        check("short_low_locked", LOCKED, 1);
        check("short_low_lost", LOCK_LOST, 0);
        L2 = L + 20;
        wait_until(L2);
        DLL_LOCK = 1'b0;
        wait_until(L2 + LOCK_FILT - 1);
        check("loss_pending_locked", LOCKED, 1);
        wait_until(L2 + LOCK_FILT);
        check("loss_lost", LOCK_LOST, 1);
        check("loss_locked", LOCKED, 0);
        check("loss_valid", LANE_VALID, 0);
        wait_until(L2 + 20);
        DLL_LOCK = 1'b1;
        p = L2 + 20 + LOCK_FILT;
        exp_pulse_q.push_back(p);
        d = p + 4;
        exp_dist_q.push_back('{cyc: d, code: last_dist});
        wait_until(d);
        LANE_ACK = 2'b11;
        wait_until(d + 1);
        LANE_ACK = '0;
        check("relock_valid_clear", LANE_VALID, 0);
        wait_until(d + 2);
        check("relock_locked", LOCKED, 1);
        check("relock_lost_sticky", LOCK_LOST, 1);
        t_track = d + 2;

        // ENABLE drop with acks pending, then re-enable.
        nc = last_dist ^ 8'h01;
        DLL_CODE = nc;
        p = t_track + 4;
        exp_pulse_q.push_back(p);
        d = p + 4;
        exp_dist_q.push_back('{cyc: d, code: nc});
        wait_until(p - 1);
        DLL_DELAY_DIFF = 1'b1;
        wait_until(p);
        DLL_DELAY_DIFF = 1'b0;
        wait_until(d + 1);
        ENABLE = 1'b0;
        wait_until(d + 2);
        check("abort_pwrdn", DLL_POWERDOWN_N, 0);
        check("abort_valid", LANE_VALID, 0);
        check("abort_locked", LOCKED, 0);
        check("abort_code", LANE_CODE, 0);
        check("abort_lost", LOCK_LOST, 0);
        wait_until(d + 4);
        ENABLE = 1'b1;
        e = d + 4;
        exp_pulse_q.push_back(e + 1 + PWRUP_WAIT + LOCK_FILT);
        exp_dist_q.push_back('{cyc: e + 1 + PWRUP_WAIT + LOCK_FILT + 4, code: nc});
        wait_until(e + 1);
        check("reenable_pwrdn", DLL_POWERDOWN_N, 1);
        wait_until(e + 2);
        check("reenable_lost_clear", LOCK_LOST, 0);
        d = e + 1 + PWRUP_WAIT + LOCK_FILT + 4;
        wait_until(d);
        LANE_ACK = 2'b11;
        wait_until(d + 1);
        LANE_ACK = '0;
        wait_until(d + 2);
        check("reenable_locked", LOCKED, 1);
        last_dist = nc;
        t_track = d + 2;

        // RESET mid-handshake.
        nc = last_dist ^ 8'h80;
        DLL_CODE = nc;
        p = t_track + 1;
        exp_pulse_q.push_back(p);
        d = p + 4;
        exp_dist_q.push_back('{cyc: d, code: nc});
        wait_until(p - 1);
        DLL_DELAY_DIFF = 1'b1;
        wait_until(p);
        DLL_DELAY_DIFF = 1'b0;
        wait_until(d + 1);
        RESET = 1'b1;
        wait_until(d + 2);
        check("rst_mid_pwrdn", DLL_POWERDOWN_N, 0);
        check("rst_mid_valid", LANE_VALID, 0);
        check("rst_mid_code", LANE_CODE, 0);
        check("rst_mid_locked", LOCKED, 0);
        wait_until(d + 4);

        check("pulse_queue_drained", exp_pulse_q.size(), 0);
        check("dist_queue_drained", exp_dist_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule

// File: doc/dll_code_mgr.md
DLL_CODE_MGR -- requirements
Module: dll_code_mgr

Interface
REQ-001 The block SHALL have parameter CODE_W, default 8, meaning the DLL delay-code width.
REQ-002 The block SHALL have parameter NUM_LANES, default 2, meaning the number of lanes receiving the code.
REQ-003 The block SHALL have parameter PWRUP_WAIT, default 64, meaning the cycles from power-up before lock is evaluated.
REQ-004 The block SHALL have parameter LOCK_FILT, default 16, meaning the consecutive cycles needed to qualify lock gain or loss.
REQ-005 The block SHALL have parameter UPDATE_PERIOD, default 1024, meaning the cycles between periodic code refreshes.
REQ-006 CLK, input, 1, the single clock; all logic is on the rising edge.
REQ-007 RESET, input, 1, reset; synchronous and active-high.
REQ-008 ENABLE, input, 1, run request; low forces power-down.
REQ-009 DLL_LOCK, input, 1, raw DLL lock.
REQ-010 DLL_DELAY_DIFF, input, 1, DLL drift indication.
REQ-011 DLL_CODE, input, CODE_W, DLL delay code.
REQ-012 DLL_POWERDOWN_N, output, 1, DLL power control; 1 means powered.
REQ-013 DLL_CODE_UPDATE, output, 1, single-cycle code-latch pulse to the DLL.
REQ-014 LANE_CODE, output, NUM_LANES*CODE_W, per-lane code; lane i occupies bits [i*CODE_W +: CODE_W].
REQ-015 LANE_VALID, output, NUM_LANES, per-lane "new code offered" flag.
REQ-016 LANE_ACK, input, NUM_LANES, per-lane acceptance.
REQ-017 LOCKED, output, 1, filtered lock with the code distributed.
REQ-018 LOCK_LOST, output, 1, sticky flag set on filtered lock loss.

Function
REQ-019 The FSM SHALL have the states OFF, PWRUP, LOCK_WAIT, UPDATE, SAMPLE, DISTRIBUTE and TRACK.
REQ-020 In OFF, DLL_POWERDOWN_N SHALL be 0 and all other outputs SHALL hold their reset values; ENABLE=1 SHALL cause a transition to PWRUP.
REQ-021 In PWRUP, DLL_POWERDOWN_N SHALL be 1, and the FSM SHALL count PWRUP_WAIT cycles and then enter LOCK_WAIT.
REQ-022 In LOCK_WAIT, the FSM SHALL enter UPDATE after DLL_LOCK has been 1 for LOCK_FILT consecutive cycles; a 0 on DLL_LOCK SHALL reset the count.
REQ-023 On entry to UPDATE, DLL_CODE_UPDATE SHALL be 1 for exactly one cycle, and the FSM SHALL then enter SAMPLE.
REQ-024 SAMPLE SHALL wait 2 cycles and then register DLL_CODE (3-cycle latency from the pulse to the captured code).
REQ-025 If the captured code equals the last distributed code and this is not the first distribution since lock, the FSM SHALL skip DISTRIBUTE and enter TRACK.
REQ-026 In DISTRIBUTE, every LANE_CODE slice SHALL be loaded with the captured code and all LANE_VALID bits SHALL be set in the same cycle.
REQ-027 LANE_VALID[i] SHALL clear in the cycle after LANE_ACK[i]=1 while LANE_VALID[i]=1; LANE_ACK[i] while LANE_VALID[i]=0 SHALL be ignored.
REQ-028 LANE_CODE SHALL remain stable while any LANE_VALID bit is 1.
REQ-029 The FSM SHALL enter TRACK once all LANE_VALID bits are 0; acknowledgements on the same cycle the bits are set SHALL be honoured.
REQ-030 LOCKED SHALL be 1 only in TRACK.
REQ-031 TRACK SHALL count UPDATE_PERIOD cycles and then enter UPDATE, clearing the counter.
REQ-032 DLL_DELAY_DIFF=1 in TRACK SHALL force UPDATE on the next cycle.
REQ-033 If a period expiry and DLL_DELAY_DIFF occur in the same cycle, only one UPDATE SHALL result.
REQ-034 In states UPDATE through TRACK, DLL_LOCK=0 for LOCK_FILT consecutive cycles SHALL set LOCK_LOST, clear all LANE_VALID bits, and force LOCK_WAIT.
REQ-035 LOCK_LOST SHALL clear only on RESET or on an ENABLE 0->1 transition.
REQ-036 ENABLE=0 in any state SHALL force OFF on the next cycle; this abort SHALL override lock loss and the update triggers.
REQ-037 Counters SHALL be sized to clog2(max parameter + 1) and SHALL saturate without wrapping.

Reset
REQ-038 While RESET=1, the FSM SHALL be in OFF.
REQ-039 While RESET=1, DLL_POWERDOWN_N, DLL_CODE_UPDATE, LANE_VALID, LOCKED and LOCK_LOST SHALL be 0.
REQ-040 While RESET=1, LANE_CODE, the captured code and all counters SHALL be 0.
REQ-041 RESET mid-handshake SHALL drop LANE_VALID without waiting for LANE_ACK.
REQ-042 RESET SHALL take priority over all other inputs.

Structure
REQ-043 The FSM state enum and the SAMPLE_DLY=2 constant SHALL reside in the shared package dll_pkg.
REQ-044 The lock qualifier (consecutive-cycle filter for gain and loss) SHALL be one sub-module, dll_lock_filt, parametrised by LOCK_FILT.
REQ-045 Per-lane valid/ack logic SHALL be a generate loop and SHALL NOT be a separate module.

Verification
REQ-046 Bring-up: ENABLE=1, DLL_LOCK=1 from cycle 10, DLL_CODE=8'h5A -> DLL_POWERDOWN_N=1 at cycle 1, one DLL_CODE_UPDATE pulse at cycle 1+64+16, both lanes get 8'h5A, and LOCKED=1 after both ACKs.
REQ-047 Periodic refresh with unchanged code -> a DLL_CODE_UPDATE pulse every 1024+4 cycles with LANE_VALID never set; after changing the code to 8'h5B, the next refresh sets LANE_VALID=2'b11.
REQ-048 Staggered ACK: lane0 ACK at +1 and lane1 ACK at +7 -> LANE_VALID goes 11, 10, then 00, and TRACK is entered in the cycle after lane1 clears.
REQ-049 DLL_LOCK low for 15 cycles -> no effect; low for 16 cycles -> LOCK_LOST=1, LOCKED=0, state LOCK_WAIT, and re-lock then redistributes.
REQ-050 DLL_DELAY_DIFF pulsed on the same cycle as period expiry -> exactly one DLL_CODE_UPDATE pulse.
REQ-051 ENABLE=0 during DISTRIBUTE with ACKs pending -> next cycle is OFF, DLL_POWERDOWN_N=0 and LANE_VALID=0; RESET asserted mid-handshake gives the same result.
